// File: rtl/pipeline_pkg.sv
// Shared types for the MEM stage: pipeline register layouts, access FSM states
// and the zero-register index that is never written.
package pipeline_pkg;

  localparam int XLEN   = 64;
  localparam int RIDX_W = 5;
  localparam logic [RIDX_W-1:0] XZR = 5'd31;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   result;
    logic [XLEN-1:0]   store_data;
    logic [RIDX_W-1:0] Rd;
    logic              MemToReg;
    logic              RegWrite;
    logic              MemWrite;
  } ex_mem_t;

  typedef struct packed {
    logic              valid;
    logic [RIDX_W-1:0] Rd;
    logic              RegWrite;
    logic [XLEN-1:0]   data;
  } mem_wb_t;

  typedef enum logic [1:0] {IDLE, ACCESS, FAULT} mem_state_t;

  // A store never writes the register file, and neither does any write to XZR.
  function automatic logic writes_reg(input logic reg_write, input logic mem_write,
                                      input logic [RIDX_W-1:0] rd);
    return reg_write & ~mem_write & (rd != XZR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory wait states; terminal fires on the wait cycle that
// would bring the count to MAX_WAIT.
module mem_wait_timer #(
  parameter int MAX_WAIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = enable & (count == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, data-memory handshake with timeout fault,
// EX bypass of non-load results and the MEM/WB register.
module mem_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W   = XLEN,   // must match the package struct width
  parameter int REG_W    = RIDX_W,
  parameter int MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_W-1:0]  ex_Rd,
  input  logic              ex_MemToReg,
  input  logic              ex_RegWrite,
  input  logic              ex_MemWrite,
  output logic              stall_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_Rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic              wb_valid,
  output logic [REG_W-1:0]  wb_Rd,
  output logic              wb_RegWrite,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_fault
);

  ex_mem_t    ex_mem_p0;
  ex_mem_t    ex_in;
  mem_wb_t    mem_wb_p1;
  mem_state_t state;
  logic       is_mem;
  logic       waiting;
  logic       timeout;
  logic       faulted;

  always_comb begin
    ex_in = '0;
    if (ex_valid) begin
      ex_in.valid      = 1'b1;
      ex_in.result     = ex_result;
      ex_in.store_data = ex_store_data;
      ex_in.Rd         = ex_Rd;
      ex_in.MemToReg   = ex_MemToReg;
      ex_in.RegWrite   = ex_RegWrite;
      ex_in.MemWrite   = ex_MemWrite;
    end
  end

  // ---- EX/MEM boundary ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_mem_p0 <= '0;
    end else if (!stall_out) begin
      ex_mem_p0 <= ex_in;
    end
  end

  assign is_mem  = ex_mem_p0.valid & (ex_mem_p0.MemToReg | ex_mem_p0.MemWrite);
  assign faulted = (state == FAULT);

  // Requests go out in the same cycle the op lands in EX/MEM; a faulted stage
  // lets memory ops drain without touching memory.
  assign mem_req   = is_mem & ~faulted;
  assign mem_we    = mem_req & ex_mem_p0.MemWrite;
  assign mem_addr  = ex_mem_p0.result;
  assign mem_wdata = ex_mem_p0.store_data;
  assign waiting   = mem_req & ~mem_ready;
  assign stall_out = waiting;

  assign fwd_valid = ex_mem_p0.valid & ex_mem_p0.RegWrite & ~ex_mem_p0.MemToReg &
                     (ex_mem_p0.Rd != XZR);
  assign fwd_Rd    = ex_mem_p0.Rd;
  assign fwd_data  = ex_mem_p0.result;

  mem_wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (~waiting),
    .enable  (waiting),
    .terminal(timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mem_fault <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCESS: begin
          if (timeout) begin
            state     <= FAULT;
            mem_fault <= 1'b1;
          end else if (waiting) begin
            state <= ACCESS;
          end else begin
            state <= IDLE;
          end
        end
        FAULT:   state <= FAULT;
        default: state <= IDLE;
      endcase
    end
  end

  // ---- MEM/WB boundary ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_wb_p1 <= '0;
    end else if (stall_out) begin
      mem_wb_p1.valid    <= 1'b0;
      mem_wb_p1.RegWrite <= 1'b0;
    end else begin
      mem_wb_p1.valid    <= ex_mem_p0.valid;
      mem_wb_p1.Rd       <= ex_mem_p0.Rd;
      mem_wb_p1.RegWrite <= ex_mem_p0.valid & ~(is_mem & faulted) &
                            writes_reg(ex_mem_p0.RegWrite, ex_mem_p0.MemWrite, ex_mem_p0.Rd);
      mem_wb_p1.data     <= ex_mem_p0.MemToReg ? mem_rdata : ex_mem_p0.result;
    end
  end

  assign wb_valid    = mem_wb_p1.valid;
  assign wb_Rd       = mem_wb_p1.Rd;
  assign wb_RegWrite = mem_wb_p1.RegWrite;
  assign wb_data     = mem_wb_p1.data;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, hand-built reset/timeout sequences
// and randomized instruction streams against a cycle-level reference model.
module tb_mem_stage;

  localparam int DW   = 64;
  localparam int RW   = 5;
  localparam int MAXW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          ex_valid;
  logic [DW-1:0] ex_result, ex_store_data;
  logic [RW-1:0] ex_Rd;
  logic          ex_MemToReg, ex_RegWrite, ex_MemWrite;
  logic          stall_out, mem_req, mem_we;
  logic [DW-1:0] mem_addr, mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic          fwd_valid;
  logic [RW-1:0] fwd_Rd;
  logic [DW-1:0] fwd_data;
  logic          wb_valid;
  logic [RW-1:0] wb_Rd;
  logic          wb_RegWrite;
  logic [DW-1:0] wb_data;
  logic          mem_fault;

  mem_stage #(.DATA_W(DW), .REG_W(RW), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_result(ex_result),
    .ex_store_data(ex_store_data), .ex_Rd(ex_Rd), .ex_MemToReg(ex_MemToReg),
    .ex_RegWrite(ex_RegWrite), .ex_MemWrite(ex_MemWrite), .stall_out(stall_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .fwd_valid(fwd_valid),
    .fwd_Rd(fwd_Rd), .fwd_data(fwd_data), .wb_valid(wb_valid), .wb_Rd(wb_Rd),
    .wb_RegWrite(wb_RegWrite), .wb_data(wb_data), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [63:0] res, sd, rdata, e_data;
    logic [4:0]  rd;
    logic        m2r, rw, mw, e_req, e_we, e_fwd, e_wrt;
    int          waits, e_stall;
  } vec_t;

  typedef struct {
    logic        v;
    logic [63:0] res, sd, rdata;
    logic [4:0]  rd;
    logic        m2r, rw, mw;
    int          waits;
  } instr_t;

  instr_t q[$];
  bit     mfault;

  function automatic vec_t mk(logic [63:0] res, logic [63:0] sd, logic [4:0] rd,
                              logic m2r, logic rw, logic mw, int waits, logic [63:0] rdata,
                              int e_stall, logic e_req, logic e_we, logic e_fwd,
                              logic e_wrt, logic [63:0] e_data);
    vec_t v;
    v.res = res; v.sd = sd; v.rd = rd; v.m2r = m2r; v.rw = rw; v.mw = mw;
    v.waits = waits; v.rdata = rdata; v.e_stall = e_stall; v.e_req = e_req;
    v.e_we = e_we; v.e_fwd = e_fwd; v.e_wrt = e_wrt; v.e_data = e_data;
    return v;
  endfunction

  function automatic instr_t mk_i(logic [63:0] res, logic [4:0] rd, logic m2r, logic rw,
                                  logic mw, int waits, logic [63:0] rdata);
    instr_t t;
    t.v = 1'b1; t.res = res; t.sd = 64'h0; t.rd = rd; t.m2r = m2r; t.rw = rw;
    t.mw = mw; t.waits = waits; t.rdata = rdata;
    return t;
  endfunction

  function automatic instr_t rand_instr(int maxw);
    instr_t t;
    int k;
    k = $urandom_range(0, 3);
    t.v     = ($urandom_range(0, 4) != 0);
    t.m2r   = (k == 1) || (k == 3);
    t.mw    = (k >= 2);
    t.rw    = 1'($urandom_range(0, 1));
    t.rd    = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
    t.res   = {$urandom, $urandom};
    t.sd    = {$urandom, $urandom};
    t.rdata = {$urandom, $urandom};
    t.waits = $urandom_range(0, maxw);
    return t;
  endfunction

  task automatic drive(input instr_t t);
    ex_valid = t.v; ex_result = t.res; ex_store_data = t.sd; ex_Rd = t.rd;
    ex_MemToReg = t.m2r; ex_RegWrite = t.rw; ex_MemWrite = t.mw;
  endtask

  task automatic do_reset();
    reset = 1'b1; ex_valid = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mfault = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    int  stalls;
    bit  done;
    instr_t t;
    stalls = 0; done = 0;
    t = mk_i(v.res, v.rd, v.m2r, v.rw, v.mw, v.waits, v.rdata);
    t.sd = v.sd;
    @(negedge clk);
    drive(t); mem_ready = 1'b0;
    @(posedge clk);
    #1 ex_valid = 1'b0;
    for (int c = 0; c < 12 && !done; c++) begin
      @(negedge clk);
      mem_ready = (c == v.waits); mem_rdata = v.rdata;
      #1;
      if (c == 0) begin
        chk("vec_fwd_valid", fwd_valid, v.e_fwd);
        if (v.e_fwd) chk("vec_fwd_data", fwd_data, v.res);
        chk("vec_mem_req", mem_req, v.e_req);
        if (v.e_req) begin
          chk("vec_mem_we", mem_we, v.e_we);
          chk("vec_mem_addr", mem_addr, v.res);
          if (v.e_we) chk("vec_mem_wdata", mem_wdata, v.sd);
        end
      end
      chk("vec_wb_bubble", wb_valid, 1'b0);
      if (stall_out) stalls++;
      else done = 1;
      @(posedge clk);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("vec_stall_cycles", 64'(stalls), 64'(v.e_stall));
    chk("vec_wb_valid", wb_valid, 1'b1);
    chk("vec_wb_Rd", wb_Rd, v.rd);
    chk("vec_wb_RegWrite", wb_RegWrite, v.e_wrt);
    if (v.e_wrt) chk("vec_wb_data", wb_data, v.e_data);
  endtask

  // Reference model: each op sits in M for min(waits, MAXW) stalled cycles (none
  // once faulted), then retires; a timed-out op sets the sticky fault and
  // retires one cycle later without touching memory.
  task automatic run_stream();
    instr_t cur, nxt, bub;
    int     waited, guard;
    bit     ismem, req, stl, fexp;
    bit     p_v, p_wr;
    logic [4:0]  p_rd;
    logic [63:0] p_data;
    bub = '{default: '0};
    cur = bub; waited = 0; guard = 0;
    p_v = 0; p_wr = 0; p_rd = '0; p_data = '0;
    @(negedge clk);
    nxt = (q.size() != 0) ? q.pop_front() : bub;
    drive(nxt);
    while ((cur.v || nxt.v || q.size() != 0 || p_v) && guard < 3000) begin
      guard++;
      ismem = cur.v & (cur.m2r | cur.mw);
      req   = ismem & ~mfault;
      stl   = req & (waited < cur.waits);
      mem_ready = req ? !stl : 1'($urandom_range(0, 1));
      mem_rdata = req ? cur.rdata : {$urandom, $urandom};
      #1;
      chk("s_mem_req", mem_req, req);
      chk("s_stall", stall_out, stl);
      chk("s_fault", mem_fault, mfault);
      chk("s_wb_valid", wb_valid, p_v);
      if (p_v) begin
        chk("s_wb_Rd", wb_Rd, p_rd);
        chk("s_wb_RegWrite", wb_RegWrite, p_wr);
        if (p_wr) chk("s_wb_data", wb_data, p_data);
      end
      fexp = cur.v & cur.rw & ~cur.m2r & (cur.rd != 5'd31);
      chk("s_fwd_valid", fwd_valid, fexp);
      if (fexp) begin
        chk("s_fwd_Rd", fwd_Rd, cur.rd);
        chk("s_fwd_data", fwd_data, cur.res);
      end
      if (req) begin
        chk("s_mem_we", mem_we, cur.mw);
        chk("s_mem_addr", mem_addr, cur.res);
        if (cur.mw) chk("s_mem_wdata", mem_wdata, cur.sd);
      end
      @(posedge clk);
      if (stl) begin
        waited++;
        p_v = 0;
        if (waited == MAXW) mfault = 1;
      end else begin
        p_v    = cur.v;
        p_rd   = cur.rd;
        p_wr   = cur.v & cur.rw & ~cur.mw & (cur.rd != 5'd31) & ~(ismem & mfault);
        p_data = cur.m2r ? cur.rdata : cur.res;
        cur    = nxt;
        waited = 0;
        nxt    = (q.size() != 0) ? q.pop_front() : bub;
      end
      @(negedge clk);
      drive(nxt);
    end
    if (guard >= 3000) chk("s_stream_timeout", 64'(guard), 64'd0);
    mem_ready = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(64'h2A, 64'h0,    5'd3,  0, 1, 0, 0, 64'h0,    0, 0, 0, 1, 1, 64'h2A);
    vecs[1] = mk(64'h40, 64'h0,    5'd5,  1, 1, 0, 3, 64'hDEAD, 3, 1, 0, 0, 1, 64'hDEAD);
    vecs[2] = mk(64'h80, 64'h1234, 5'd2,  0, 0, 1, 0, 64'h0,    0, 1, 1, 0, 0, 64'h0);
    vecs[3] = mk(64'h100,64'h0,    5'd31, 1, 1, 0, 1, 64'h77,   1, 1, 0, 0, 0, 64'h0);
    vecs[4] = mk(64'h5,  64'h0,    5'd31, 0, 1, 0, 0, 64'h0,    0, 0, 0, 0, 0, 64'h0);
    vecs[5] = mk(64'hC0, 64'h99,   5'd7,  1, 1, 1, 2, 64'h5,    2, 1, 1, 0, 0, 64'h0);
    vecs[6] = mk(64'h3C, 64'h0,    5'd9,  0, 0, 0, 0, 64'h0,    0, 0, 0, 0, 0, 64'h0);
    vecs[7] = mk(64'h8,  64'h0,    5'd1,  1, 1, 0, 0, 64'hCAFE, 0, 1, 0, 0, 1, 64'hCAFE);

    ex_result = '0; ex_store_data = '0; ex_Rd = '0;
    ex_MemToReg = 0; ex_RegWrite = 0; ex_MemWrite = 0;
    reset = 1'b1; ex_valid = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    @(negedge clk);
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_stall", stall_out, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_RegWrite", wb_RegWrite, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_fwd_valid", fwd_valid, 0);
    chk("rst_mem_fault", mem_fault, 0);
    chk("rst_mem_addr", mem_addr, 0);
    do_reset();

    foreach (vecs[i]) apply_vec(vecs[i]);

    for (int i = 0; i < 200; i++) q.push_back(rand_instr(MAXW - 1));
    run_stream();

    // Reset while a load is waiting: outputs drop without a clock edge.
    do_reset();
    @(negedge clk);
    drive(mk_i(64'h11, 5'd3, 0, 1, 0, 0, 64'h0));
    @(posedge clk);
    #1 drive(mk_i(64'h40, 5'd5, 1, 1, 0, 9, 64'h0));
    @(posedge clk);
    #1 ex_valid = 1'b0;
    #1;
    chk("mid_wb_valid_before", wb_valid, 1);
    chk("mid_req_before", mem_req, 1);
    chk("mid_stall_before", stall_out, 1);
    #1 reset = 1'b1;
    #1;
    chk("mid_req_async", mem_req, 0);
    chk("mid_stall_async", stall_out, 0);
    chk("mid_wb_valid_async", wb_valid, 0);
    @(negedge clk);
    reset = 1'b0; mfault = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_req", mem_req, 0);
    chk("post_rst_stall", stall_out, 0);
    chk("post_rst_fault", mem_fault, 0);

    // Timeout: the first load never gets mem_ready, later memory ops drain.
    q.push_back(mk_i(64'h200, 5'd4, 1, 1, 0, 99, 64'h1));
    q.push_back(mk_i(64'h208, 5'd6, 1, 1, 0, 0, 64'h2));
    q.push_back(mk_i(64'h55, 5'd2, 0, 1, 0, 0, 64'h0));
    run_stream();
    #1 chk("fault_sticky", mem_fault, 1);

    for (int i = 0; i < 40; i++) q.push_back(rand_instr(6));
    run_stream();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
